// File: rtl/uart_frame_rx.sv
// -----------------------------------------------------------------------------
// uart_frame_rx
//
// Purpose:
//   Consumes bytes from a byte-wide UART receiver (recved/ack handshake),
//   hunts for a sync byte and assembles a framed packet:
//       SYNC, LEN, LEN payload bytes, CSUM
//   The 8-bit modular sum of LEN, all payload bytes and CSUM must be zero.
//   A validated payload is held in an internal buffer and presented to the
//   command logic through a valid/ack handshake with random-access reads.
//   Checksum, length and inter-byte timeout errors are flagged with
//   one-cycle pulses.
//
// Ports:
//   clk          system clock, rising edge
//   res          synchronous reset, active low
//   rx_data      byte from UART receiver, valid while rx_recved=1
//   rx_recved    receiver holds a byte awaiting ack
//   rx_ack       one-cycle pulse: byte consumed
//   pkt_valid    validated packet available
//   pkt_len      payload length of the presented packet
//   rd_addr      payload read index
//   rd_data      buffer[rd_addr], combinational read
//   pkt_ack      consumer releases the packet
//   err_csum     one-cycle pulse: checksum mismatch
//   err_len      one-cycle pulse: LEN > MAX_PAYLOAD
//   err_timeout  one-cycle pulse: inter-byte timeout inside a frame
// -----------------------------------------------------------------------------
module uart_frame_rx #(
    parameter int          MAX_PAYLOAD    = 16,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 500000,
    localparam int         AW             = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
    input  logic          clk,
    input  logic          res,
    input  logic [7:0]    rx_data,
    input  logic          rx_recved,
    output logic          rx_ack,
    output logic          pkt_valid,
    output logic [7:0]    pkt_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          pkt_ack,
    output logic          err_csum,
    output logic          err_len,
    output logic          err_timeout
);

    localparam logic [2:0] S_SYNC    = 3'd0;
    localparam logic [2:0] S_LEN     = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_CSUM    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

    // Counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    r_state;
    logic          r_ack;
    logic          r_valid;
    logic [7:0]    r_len;
    logic [7:0]    r_sum;
    logic [AW-1:0] r_idx;
    logic [TW-1:0] r_tcnt;
    logic          r_err_csum;
    logic          r_err_len;
    logic          r_err_timeout;
    logic [7:0]    r_buf [MAX_PAYLOAD];

    logic          w_accept;
    logic          w_in_frame;
    logic [7:0]    w_csum;
    logic          w_last_payload;

    // The receiver keeps recved high during the ack cycle, so r_ack blocks a
    // double accept of the same byte. S_DONE withholds ack as backpressure.
    assign w_accept       = rx_recved && !r_ack && (r_state != S_DONE);
    assign w_in_frame     = (r_state == S_LEN) || (r_state == S_PAYLOAD) ||
                            (r_state == S_CSUM);
    assign w_csum         = r_sum + rx_data;
    assign w_last_payload = (8'(r_idx) == (r_len - 8'd1));

    always_ff @(posedge clk) begin
        if (!res) begin
            r_state       <= S_SYNC;
            r_ack         <= 1'b0;
            r_valid       <= 1'b0;
            r_len         <= 8'd0;
            r_sum         <= 8'd0;
            r_idx         <= '0;
            r_tcnt        <= '0;
            r_err_csum    <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout sequential logic, so
            // every branch below sees the pre-edge values of r_* registers;
            // the defaults here make the error flags single-cycle pulses.
            r_ack         <= w_accept;
            r_err_csum    <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;

            if (w_accept) begin
                r_tcnt <= '0;
                case (r_state)
                    S_SYNC: begin
                        if (rx_data == SYNC_BYTE) r_state <= S_LEN;
                    end
                    S_LEN: begin
                        if (rx_data > MAX_LEN) begin
                            r_err_len <= 1'b1;
                            r_state   <= S_SYNC;
                        end else begin
                            r_len   <= rx_data;
                            r_sum   <= rx_data;
                            r_idx   <= '0;
                            r_state <= (rx_data == 8'd0) ? S_CSUM : S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        r_sum <= w_csum;
                        if (w_last_payload) r_state <= S_CSUM;
                        else                r_idx   <= r_idx + 1'b1;
                    end
                    S_CSUM: begin
                        if (w_csum == 8'd0) begin
                            r_state <= S_DONE;
                            r_valid <= 1'b1;
                        end else begin
                            r_err_csum <= 1'b1;
                            r_state    <= S_SYNC;
                        end
                    end
                    default: r_state <= S_SYNC;
                endcase
            end else if (w_in_frame) begin
                if (r_tcnt == TCNT_LAST) begin
                    r_err_timeout <= 1'b1;
                    r_state       <= S_SYNC;
                    r_tcnt        <= '0;
                end else begin
                    r_tcnt <= r_tcnt + 1'b1;
                end
            end

            // Accept is impossible in S_DONE, so this never races the case above.
            if ((r_state == S_DONE) && pkt_ack) begin
                r_valid <= 1'b0;
                r_state <= S_SYNC;
            end
        end
    end

    // NOTE: the payload buffer has no reset; its contents are only meaningful
    // below pkt_len while pkt_valid=1, and skipping reset keeps it a plain RAM.
    // Writes happen only in S_PAYLOAD, so a presented packet is never disturbed.
    always_ff @(posedge clk) begin
        if (res && w_accept && (r_state == S_PAYLOAD)) begin
            r_buf[r_idx] <= rx_data;
        end
    end

    assign rd_data     = r_buf[rd_addr];
    assign rx_ack      = r_ack;
    assign pkt_valid   = r_valid;
    assign pkt_len     = r_len;
    assign err_csum    = r_err_csum;
    assign err_len     = r_err_len;
    assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_uart_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_rx
//
// Directed bench for uart_frame_rx with MAX_PAYLOAD=16, TIMEOUT_CYCLES=100.
// A small receiver model presents one byte at a time and drops recved one
// cycle after it sees rx_ack. Pulse counters sampled on the falling edge
// record rx_ack and err_* activity.
// -----------------------------------------------------------------------------
module tb_uart_frame_rx;

    localparam int MAX_PAYLOAD    = 16;
    localparam int TIMEOUT_CYCLES = 100;
    localparam int AW             = 4;

    logic          clk;
    logic          res;
    logic [7:0]    rx_data;
    logic          rx_recved;
    logic          rx_ack;
    logic          pkt_valid;
    logic [7:0]    pkt_len;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          pkt_ack;
    logic          err_csum;
    logic          err_len;
    logic          err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    int n_ack  = 0;
    int n_csum = 0;
    int n_len  = 0;
    int n_to   = 0;

    uart_frame_rx #(
        .MAX_PAYLOAD    (MAX_PAYLOAD),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .res         (res),
        .rx_data     (rx_data),
        .rx_recved   (rx_recved),
        .rx_ack      (rx_ack),
        .pkt_valid   (pkt_valid),
        .pkt_len     (pkt_len),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .pkt_ack     (pkt_ack),
        .err_csum    (err_csum),
        .err_len     (err_len),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_ack)      n_ack++;
        if (err_csum)    n_csum++;
        if (err_len)     n_len++;
        if (err_timeout) n_to++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [7:0] b);
        @(negedge clk);
        rx_data   = b;
        rx_recved = 1'b1;
    endtask

    // Waits (bounded) for the ack pulse, then releases the byte one cycle later
    // like the real receiver, checking the pulse lasted exactly one cycle.
    task automatic wait_ack(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (rx_ack) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_ack_seen"}, 32'(seen), 32'd1);
        @(posedge clk); #1;
        rx_recved = 1'b0;
        check({tag, "_ack_width"}, 32'(rx_ack), 32'd0);
    endtask

    task automatic send(input logic [7:0] b);
        present(b);
        wait_ack($sformatf("byte_%02h", b));
    endtask

    task automatic pulse_pkt_ack(input string tag);
        @(negedge clk);
        pkt_ack = 1'b1;
        @(negedge clk);
        pkt_ack = 1'b0;
        check({tag, "_valid_drop"}, 32'(pkt_valid), 32'd0);
    endtask

    task automatic read_chk(input string tag, input logic [AW-1:0] a, input logic [7:0] exp);
        rd_addr = a;
        #1;
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        int a0, e0, e1, e2, wait_cycles;
        bit to_seen;

        res       = 1'b0;
        rx_data   = 8'h00;
        rx_recved = 1'b0;
        rd_addr   = '0;
        pkt_ack   = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_ack",    32'(rx_ack),      32'd0);
        check("rst_pkt_valid", 32'(pkt_valid),   32'd0);
        check("rst_pkt_len",   32'(pkt_len),     32'd0);
        check("rst_err_csum",  32'(err_csum),    32'd0);
        check("rst_err_len",   32'(err_len),     32'd0);
        check("rst_err_to",    32'(err_timeout), 32'd0);
        res = 1'b1;

        // ---- good frame A5 03 11 22 33 97 ----
        a0 = n_ack;
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        check("good_not_valid_early", 32'(pkt_valid), 32'd0);
        send(8'h97);
        check("good_ack_count", 32'(n_ack - a0), 32'd6);
        check("good_valid", 32'(pkt_valid), 32'd1);
        check("good_len",   32'(pkt_len),   32'd3);
        read_chk("good_rd0", 4'd0, 8'h11);
        read_chk("good_rd1", 4'd1, 8'h22);
        read_chk("good_rd2", 4'd2, 8'h33);
        pulse_pkt_ack("good");

        // ---- garbage then zero-length frame ----
        a0 = n_ack;
        send(8'h00); send(8'hFF);
        check("garbage_no_valid", 32'(pkt_valid), 32'd0);
        send(8'hA5); send(8'h00); send(8'h00);
        check("zero_ack_count", 32'(n_ack - a0), 32'd5);
        check("zero_valid", 32'(pkt_valid), 32'd1);
        check("zero_len",   32'(pkt_len),   32'd0);
        read_chk("zero_buf_kept", 4'd0, 8'h11);
        pulse_pkt_ack("zero");

        // ---- bad checksum, then good 1-byte frame ----
        e0 = n_csum;
        send(8'hA5); send(8'h02); send(8'h01); send(8'h02); send(8'h00);
        @(negedge clk);
        check("csum_err_count", 32'(n_csum - e0), 32'd1);
        check("csum_no_valid",  32'(pkt_valid),   32'd0);
        send(8'hA5); send(8'h01); send(8'h55); send(8'hAA);
        check("after_csum_valid", 32'(pkt_valid), 32'd1);
        check("after_csum_len",   32'(pkt_len),   32'd1);
        read_chk("after_csum_rd0", 4'd0, 8'h55);
        check("after_csum_err_once", 32'(n_csum - e0), 32'd1);
        pulse_pkt_ack("after_csum");

        // ---- length overflow ----
        e0 = n_len;
        send(8'hA5); send(8'h11);
        @(negedge clk);
        check("len_err_count", 32'(n_len - e0), 32'd1);
        check("len_no_valid",  32'(pkt_valid),  32'd0);
        send(8'hA5); send(8'h01); send(8'h07); send(8'hF8);
        check("after_len_valid", 32'(pkt_valid), 32'd1);
        check("after_len_len",   32'(pkt_len),   32'd1);
        read_chk("after_len_rd0", 4'd0, 8'h07);
        pulse_pkt_ack("after_len");

        // ---- inter-byte timeout ----
        e0 = n_to; e1 = n_csum; e2 = n_len;
        send(8'hA5); send(8'h02); send(8'h01);
        to_seen = 1'b0;
        wait_cycles = 0;
        for (int i = 1; i <= 150; i++) begin
            @(negedge clk);
            if (n_to != e0) begin
                to_seen = 1'b1;
                wait_cycles = i;
                break;
            end
        end
        check("to_seen", 32'(to_seen), 32'd1);
        check("to_not_early", 32'(wait_cycles >= 95), 32'd1);
        check("to_not_late",  32'(wait_cycles <= 105), 32'd1);
        @(negedge clk);
        check("to_single_pulse", 32'(n_to - e0), 32'd1);
        send(8'h02);
        repeat (3) @(negedge clk);
        check("to_02_dropped", 32'(pkt_valid), 32'd0);
        check("to_no_other_err", 32'((n_csum - e1) + (n_len - e2)), 32'd0);

        // ---- backpressure ----
        send(8'hA5); send(8'h01); send(8'h55); send(8'hAA);
        check("bp_first_valid", 32'(pkt_valid), 32'd1);
        a0 = n_ack;
        present(8'hA5);
        repeat (20) @(negedge clk);
        check("bp_ack_withheld", 32'(n_ack - a0), 32'd0);
        check("bp_still_valid",  32'(pkt_valid),  32'd1);
        read_chk("bp_first_rd0", 4'd0, 8'h55);
        pulse_pkt_ack("bp");
        wait_ack("bp_sync");
        send(8'h02); send(8'hAB); send(8'hCD); send(8'h86);
        check("bp_second_valid", 32'(pkt_valid), 32'd1);
        check("bp_second_len",   32'(pkt_len),   32'd2);
        read_chk("bp_second_rd0", 4'd0, 8'hAB);
        read_chk("bp_second_rd1", 4'd1, 8'hCD);
        pulse_pkt_ack("bp_second");

        // ---- reset mid-payload ----
        send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
        check("mid_len_latched", 32'(pkt_len), 32'd4);
        @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        res = 1'b1;
        check("mid_rst_rx_ack",    32'(rx_ack),      32'd0);
        check("mid_rst_valid",     32'(pkt_valid),   32'd0);
        check("mid_rst_len",       32'(pkt_len),     32'd0);
        check("mid_rst_errs",      32'({err_csum, err_len, err_timeout}), 32'd0);
        // Remaining payload bytes are now hunted as sync and dropped.
        send(8'h03); send(8'h04);
        check("mid_partial_dropped", 32'(pkt_valid), 32'd0);
        send(8'hA5); send(8'h01); send(8'h07); send(8'hF8);
        check("mid_after_valid", 32'(pkt_valid), 32'd1);
        read_chk("mid_after_rd0", 4'd0, 8'h07);
        pulse_pkt_ack("mid_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
